// File: rtl/l2_plru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_plru_pkg
// Description : Shared constants and types for the 16-way L2 tree-PLRU.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_plru_pkg;

    localparam int WAYS   = 16;
    localparam int WAY_W  = 4;
    localparam int TREE_W = 15;

    // Heap-ordered tree: node n (1..15) lives in bit n-1.
    typedef logic [TREE_W-1:0] plru_tree_t;

endpackage : l2_plru_pkg
`default_nettype wire

// File: rtl/l2_plru_tree.sv
`default_nettype none
// ============================================================================
// Module      : l2_plru_tree
// Description : Combinational 16-way tree-PLRU logic. Given one set's tree
//               and an accessed way, produces the tree after that access and
//               the victim way selected by the incoming tree.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_plru_tree
    import l2_plru_pkg::*;
(
    input  logic [TREE_W-1:0] tree_i,
    input  logic [WAY_W-1:0]  way_i,
    output logic [TREE_W-1:0] next_tree_o,
    output logic [WAY_W-1:0]  victim_o
);

    logic [4:0] upd_node;
    logic [3:0] upd_bit_idx;
    logic       upd_dir;

    logic [4:0] vic_node;
    logic [3:0] vic_bit_idx;
    logic       vic_dir;

    // Walk the accessed way's path and point every visited node away from it.
    always_comb begin
        next_tree_o = tree_i;
        upd_node    = 5'd1;
        upd_bit_idx = 4'd0;
        upd_dir     = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            upd_dir                  = way_i[WAY_W-1-lvl];
            upd_bit_idx              = upd_node[3:0] - 4'd1;
            next_tree_o[upd_bit_idx] = ~upd_dir;
            upd_node                 = {upd_node[3:0], upd_dir};
        end
    end

    // Follow the node bits from the root; the directions taken, MSB first, are the victim.
    always_comb begin
        victim_o    = '0;
        vic_node    = 5'd1;
        vic_bit_idx = 4'd0;
        vic_dir     = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            vic_bit_idx             = vic_node[3:0] - 4'd1;
            vic_dir                 = tree_i[vic_bit_idx];
            victim_o[WAY_W-1-lvl]   = vic_dir;
            vic_node                = {vic_node[3:0], vic_dir};
        end
    end

endmodule : l2_plru_tree
`default_nettype wire

// File: rtl/l2_plru16.sv
`default_nettype none
// ============================================================================
// Module      : l2_plru16
// Description : Per-set 16-way tree-PLRU replacement state for the L2.
//               Updates on completed accesses, answers victim queries with a
//               one-cycle registered result, and bypasses a same-cycle update
//               to the queried set so the victim reflects that access.
//               Optional macro L2_PLRU_STATS_EN adds a saturating 16-bit
//               count of update cycles on output upd_count.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_plru16
    import l2_plru_pkg::*;
#(
    parameter  int NUM_SETS = 8,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [3:0]       upd_way,
    input  logic             query_valid,
    input  logic [IDX_W-1:0] query_idx,
`ifdef L2_PLRU_STATS_EN
    output logic [15:0]      upd_count,
`endif
    output logic             victim_valid,
    output logic [3:0]       victim_way
);

    plru_tree_t       tree_q [NUM_SETS];

    plru_tree_t       w_upd_cur_tree;
    plru_tree_t       w_upd_next_tree;
    plru_tree_t       w_query_tree;
    logic             w_same_set;
    logic [WAY_W-1:0] w_victim;
    logic [WAY_W-1:0] w_unused_upd_victim;
    plru_tree_t       w_unused_query_next;

    logic             victim_valid_q;
    logic [WAY_W-1:0] victim_way_q;

    assign w_upd_cur_tree = tree_q[upd_idx];
    assign w_same_set     = upd_valid && (upd_idx == query_idx);
    // A same-cycle update to the queried set must be visible to the victim.
    assign w_query_tree   = w_same_set ? w_upd_next_tree : tree_q[query_idx];

    l2_plru_tree u_upd_tree (
        .tree_i      (w_upd_cur_tree),
        .way_i       (upd_way),
        .next_tree_o (w_upd_next_tree),
        .victim_o    (w_unused_upd_victim)
    );

    l2_plru_tree u_query_tree (
        .tree_i      (w_query_tree),
        .way_i       (upd_way),
        .next_tree_o (w_unused_query_next),
        .victim_o    (w_victim)
    );

    generate
        for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
            // Each set's tree captures the updated tree when addressed by a valid update.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tree_q[s] <= '0;
                end else if (upd_valid && (upd_idx == IDX_W'(s))) begin
                    tree_q[s] <= w_upd_next_tree;
                end
            end
        end
    endgenerate

    // Victim result registers: valid follows the query by one cycle, way holds between queries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            victim_valid_q <= query_valid;
            if (query_valid) begin
                victim_way_q <= w_victim;
            end
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;

`ifdef L2_PLRU_STATS_EN
    logic [15:0] upd_count_q;

    // Saturating count of update cycles; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_count_q <= '0;
        end else if (upd_valid && (upd_count_q != 16'hFFFF)) begin
            upd_count_q <= upd_count_q + 16'd1;
        end
    end

    assign upd_count = upd_count_q;
`endif

endmodule : l2_plru16
`default_nettype wire

// File: tb/tb_l2_plru16.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_plru16
// Description : Self-checking bench for l2_plru16 with a heap-walk reference
//               model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_plru16;

    localparam int NUM_SETS = 8;
    localparam int IDX_W    = 3;

    logic             clk;
    logic             rst_n;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [3:0]       upd_way;
    logic             query_valid;
    logic [IDX_W-1:0] query_idx;
    logic             victim_valid;
    logic [3:0]       victim_way;
`ifdef L2_PLRU_STATS_EN
    logic [15:0]      upd_count;
`endif

    int checks;
    int errors;

    // Reference model: one direction flag per heap node (1..15) per set.
    bit   m_node [NUM_SETS][16];
    logic exp_valid;
    logic [3:0] exp_way;
    int   n_upd;

    l2_plru16 #(.NUM_SETS(NUM_SETS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_way      (upd_way),
        .query_valid  (query_valid),
        .query_idx    (query_idx),
`ifdef L2_PLRU_STATS_EN
        .upd_count    (upd_count),
`endif
        .victim_valid (victim_valid),
        .victim_way   (victim_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int s = 0; s < NUM_SETS; s++)
            for (int n = 0; n < 16; n++)
                m_node[s][n] = 1'b0;
        exp_valid = 1'b0;
        exp_way   = 4'd0;
        n_upd     = 0;
    endtask

    task automatic model_update(input int set, input int way);
        int n;
        int d;
        n = 1;
        for (int lvl = 0; lvl < 4; lvl++) begin
            d = (way >> (3 - lvl)) & 1;
            m_node[set][n] = (d == 0);
            n = 2 * n + d;
        end
    endtask

    function automatic int model_victim(input int set);
        int n;
        int way;
        n   = 1;
        way = 0;
        for (int lvl = 0; lvl < 4; lvl++) begin
            way = way * 2 + int'(m_node[set][n]);
            n   = 2 * n + int'(m_node[set][n]);
        end
        return way;
    endfunction

    function automatic int exp_count();
        return (n_upd > 65535) ? 65535 : n_upd;
    endfunction

    // Drive one cycle of traffic, advance the model, and step past the edge.
    task automatic do_cycle(input bit uv, input int ui, input int uw, input bit qv, input int qi);
        upd_valid   = uv;
        upd_idx     = IDX_W'(ui);
        upd_way     = 4'(uw);
        query_valid = qv;
        query_idx   = IDX_W'(qi);
        if (uv) begin
            model_update(ui, uw);
            n_upd++;
        end
        exp_valid = qv;
        if (qv) exp_way = 4'(model_victim(qi));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        upd_valid = 0; upd_idx = '0; upd_way = '0; query_valid = 0; query_idx = '0;
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (victim_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid actual=%0b required=0", victim_valid);
        end
        checks++;
        if (victim_way !== 4'd0) begin
            errors++; $display("FAIL reset_way actual=%0d required=0", victim_way);
        end
        rst_n = 1'b1;
        for (int s = 0; s < NUM_SETS; s++) begin
            do_cycle(0, 0, 0, 1, s);
            checks++;
            if (victim_valid !== 1'b1 || victim_way !== 4'd0) begin
                errors++;
                $display("FAIL post_reset_victim set=%0d actual=%0b/%0d required=1/0", s, victim_valid, victim_way);
            end
        end
        do_cycle(0, 0, 0, 0, 0);
        checks++;
        if (victim_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid actual=%0b required=0", victim_valid);
        end
    endtask

    task automatic test_directed();
        do_cycle(1, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (victim_way !== 4'd8) begin
            errors++; $display("FAIL upd_way0_victim actual=%0d required=8", victim_way);
        end
        do_cycle(1, 0, 8, 0, 0);
        checks++;
        if (victim_way !== 4'd8) begin
            errors++; $display("FAIL victim_hold actual=%0d required=8", victim_way);
        end
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (victim_way !== 4'd4) begin
            errors++; $display("FAIL upd_way8_victim actual=%0d required=4", victim_way);
        end
        do_cycle(1, 2, 0, 1, 3);
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 4'd0) begin
            errors++; $display("FAIL other_set_indep actual=%0b/%0d required=1/0", victim_valid, victim_way);
        end
        do_cycle(1, 3, 0, 1, 3);
        checks++;
        if (victim_way !== 4'd8) begin
            errors++; $display("FAIL bypass_same_set actual=%0d required=8", victim_way);
        end
        for (int w = 0; w < 16; w++) do_cycle(1, 5, w, 0, 0);
        do_cycle(0, 0, 0, 1, 5);
        checks++;
        if (victim_way !== 4'd0) begin
            errors++; $display("FAIL seq_0_to_15_victim actual=%0d required=0", victim_way);
        end
        do_cycle(1, 5, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 5);
        checks++;
        if (victim_way !== 4'd8) begin
            errors++; $display("FAIL seq_then_way0_victim actual=%0d required=8", victim_way);
        end
    endtask

    task automatic test_random();
        bit uv, qv;
        int ui, uw, qi;
        for (int c = 0; c < 600; c++) begin
            uv = ($urandom_range(0, 3) != 0);
            qv = ($urandom_range(0, 2) != 0);
            ui = $urandom_range(0, NUM_SETS - 1);
            uw = $urandom_range(0, 15);
            qi = ($urandom_range(0, 2) == 0) ? ui : $urandom_range(0, NUM_SETS - 1);
            do_cycle(uv, ui, uw, qv, qi);
            checks++;
            if (victim_valid !== exp_valid || victim_way !== exp_way) begin
                errors++;
                $display("FAIL random_victim cyc=%0d actual=%0b/%0d required=%0b/%0d", c, victim_valid, victim_way, exp_valid, exp_way);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        s = $urandom_range(0, NUM_SETS - 1);
        for (int c = 0; c < 40; c++) begin
            do_cycle(1, s, $urandom_range(0, 15), 1, s);
            checks++;
            if (victim_valid !== 1'b1 || victim_way !== exp_way) begin
                errors++;
                $display("FAIL b2b_same_set cyc=%0d actual=%0b/%0d required=1/%0d", c, victim_valid, victim_way, exp_way);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_cycle(1, 6, 3, 0, 0);
        do_cycle(1, 6, 12, 1, 6);
        query_valid = 1'b1;
        query_idx   = IDX_W'(6);
        upd_valid   = 1'b0;
        rst_n       = 1'b0;
        model_clear();
        #1;
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 4'd0) begin
            errors++; $display("FAIL midop_reset_out actual=%0b/%0d required=0/0", victim_valid, victim_way);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        query_valid = 1'b0;
        #1;
        checks++;
        if (victim_valid !== 1'b0) begin
            errors++; $display("FAIL midop_first_after_release actual=%0b required=0", victim_valid);
        end
        @(negedge clk);
        for (int s = 0; s < NUM_SETS; s++) begin
            do_cycle(0, 0, 0, 1, s);
            checks++;
            if (victim_way !== 4'd0) begin
                errors++; $display("FAIL midop_set_victim set=%0d actual=%0d required=0", s, victim_way);
            end
        end
    endtask

`ifdef L2_PLRU_STATS_EN
    task automatic test_stats();
        checks++;
        if (upd_count !== 16'(exp_count())) begin
            errors++; $display("FAIL stats_start actual=%0d required=%0d", upd_count, exp_count());
        end
        for (int c = 0; c < 70000; c++) begin
            do_cycle(1, $urandom_range(0, NUM_SETS - 1), $urandom_range(0, 15), 0, 0);
            if (c == 1000) begin
                checks++;
                if (upd_count !== 16'(exp_count())) begin
                    errors++; $display("FAIL stats_mid actual=%0d required=%0d", upd_count, exp_count());
                end
            end
        end
        checks++;
        if (upd_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_saturate actual=%0h required=ffff", upd_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        test_random();
`ifdef L2_PLRU_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_l2_plru16
`default_nettype wire
